// File: rtl/axi_stream_strip_header.sv
// Removes 0..W leading bytes from each AXI-Stream packet and realigns the payload to lane 0.
// Optional: define AXIS_STRIP_SHORT_PKT_ERR_EN to add the err_short_pkt pulse output.
module axi_stream_strip_header #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
    input  logic                       last_in,
    output logic                       ready_in,
    output logic                       valid_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [DATA_BYTE_WIDTH-1:0] keep_out,
    output logic                       last_out,
    input  logic                       ready_out,
    input  logic [BYTE_CNT_WIDTH:0]    strip_cnt,
    output logic                       header_valid,
    output logic [DATA_WIDTH-1:0]      header_data,
    output logic [DATA_BYTE_WIDTH-1:0] header_keep
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
    ,
    output logic                       err_short_pkt
`endif
);

    localparam int W   = DATA_BYTE_WIDTH;
    localparam int RCW = BYTE_CNT_WIDTH + 1;

    typedef enum logic [1:0] {ST_FIRST, ST_BODY, ST_FLUSH} state_t;

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  res_data_reg;
    logic [RCW-1:0]         res_cnt_reg;
    logic                   valid_out_reg;
    logic [DATA_WIDTH-1:0]  data_out_reg;
    logic [W-1:0]           keep_out_reg;
    logic                   last_out_reg;
    logic                   header_valid_reg;
    logic [DATA_WIDTH-1:0]  header_data_reg;
    logic [W-1:0]           header_keep_reg;

    logic [7:0] in_b       [W];
    logic [7:0] res_b      [W];
    logic [7:0] cat_b      [2*W];
    logic [7:0] out_b      [W];
    logic [7:0] res_next_b [W];
    logic [7:0] hdr_b      [W];

    logic [DATA_WIDTH-1:0] out_data_next;
    logic [DATA_WIDTH-1:0] res_data_next;
    logic [DATA_WIDTH-1:0] hdr_data_next;
    logic [W-1:0]          out_keep_next;
    logic [W-1:0]          hdr_keep_next;

    int     k_i, s_i, r_i, p_i, total_i, emit_cnt, next_r;
    logic   emit, emit_last;
    state_t next_state;

    logic out_free, accept, fire;

    assign out_free = !valid_out_reg || ready_out;
    assign ready_in = !rst && out_free && (state_reg != ST_FLUSH);
    assign accept   = valid_in && ready_in;
    assign fire     = accept || ((state_reg == ST_FLUSH) && out_free);

    // Byte lane 0 sits in the most significant byte of every bus.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            assign in_b[gi]  = data_in[DATA_WIDTH-1-8*gi -: 8];
            assign res_b[gi] = res_data_reg[DATA_WIDTH-1-8*gi -: 8];
            assign out_data_next[DATA_WIDTH-1-8*gi -: 8] = out_b[gi];
            assign res_data_next[DATA_WIDTH-1-8*gi -: 8] = res_next_b[gi];
            assign hdr_data_next[DATA_WIDTH-1-8*gi -: 8] = hdr_b[gi];
        end
    endgenerate

    always_comb begin
        k_i = 0;
        s_i = 0;
        r_i = int'(res_cnt_reg);
        if (state_reg != ST_FLUSH) begin
            k_i = W;
            if (last_in) begin
                k_i = 0;
                for (int j = 0; j < W; j++) begin
                    if (keep_in[j]) k_i = k_i + 1;
                end
            end
        end
        if (state_reg == ST_FIRST) begin
            r_i = 0;
            s_i = (int'(strip_cnt) > W) ? W : int'(strip_cnt);
            if (s_i > k_i) s_i = k_i;
        end
        p_i     = k_i - s_i;
        total_i = r_i + p_i;

        // Residual bytes first, then the surviving input bytes packed behind them.
        for (int j = 0; j < 2*W; j++) cat_b[j] = 8'h00;
        for (int j = 0; j < W; j++) begin
            if (j < r_i) cat_b[j] = res_b[j];
            if (j < p_i) cat_b[r_i+j] = in_b[j+s_i];
        end

        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_cnt   = 0;
        next_r     = total_i;
        next_state = state_reg;
        if (state_reg == ST_FLUSH) begin
            emit       = 1'b1;
            emit_last  = 1'b1;
            emit_cnt   = total_i;
            next_r     = 0;
            next_state = ST_FIRST;
        end else if (!last_in) begin
            next_state = ST_BODY;
            if (total_i >= W) begin
                emit     = 1'b1;
                emit_cnt = W;
                next_r   = total_i - W;
            end
        end else if (total_i == 0) begin
            next_r     = 0;
            next_state = ST_FIRST;
        end else if (total_i <= W) begin
            emit       = 1'b1;
            emit_last  = 1'b1;
            emit_cnt   = total_i;
            next_r     = 0;
            next_state = ST_FIRST;
        end else begin
            emit       = 1'b1;
            emit_cnt   = W;
            next_r     = total_i - W;
            next_state = ST_FLUSH;
        end

        for (int j = 0; j < W; j++) begin
            out_b[j]      = (j < emit_cnt) ? cat_b[j] : 8'h00;
            res_next_b[j] = (j < next_r) ? (emit ? cat_b[W+j] : cat_b[j]) : 8'h00;
            hdr_b[j]      = (j < s_i) ? in_b[j] : 8'h00;
            out_keep_next[W-1-j] = (j < emit_cnt);
            hdr_keep_next[W-1-j] = (j < s_i);
        end
    end

`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
    logic err_short_pkt_reg;
    assign err_short_pkt = err_short_pkt_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_FIRST;
            res_data_reg     <= '0;
            res_cnt_reg      <= '0;
            valid_out_reg    <= 1'b0;
            data_out_reg     <= '0;
            keep_out_reg     <= '0;
            last_out_reg     <= 1'b0;
            header_valid_reg <= 1'b0;
            header_data_reg  <= '0;
            header_keep_reg  <= '0;
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
            err_short_pkt_reg <= 1'b0;
`endif
        end else begin
            header_valid_reg <= 1'b0;
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
            err_short_pkt_reg <= 1'b0;
`endif
            if (out_free) begin
                valid_out_reg <= fire && emit;
                data_out_reg  <= (fire && emit) ? out_data_next : '0;
                keep_out_reg  <= (fire && emit) ? out_keep_next : '0;
                last_out_reg  <= fire && emit && emit_last;
            end
            if (fire) begin
                state_reg    <= next_state;
                res_cnt_reg  <= RCW'(next_r);
                res_data_reg <= res_data_next;
            end
            if (accept && (state_reg == ST_FIRST)) begin
                header_valid_reg <= 1'b1;
                header_data_reg  <= hdr_data_next;
                header_keep_reg  <= hdr_keep_next;
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
                err_short_pkt_reg <= last_in && (total_i == 0);
`endif
            end
        end
    end

    assign valid_out    = valid_out_reg;
    assign data_out     = data_out_reg;
    assign keep_out     = keep_out_reg;
    assign last_out     = last_out_reg;
    assign header_valid = header_valid_reg;
    assign header_data  = header_data_reg;
    assign header_keep  = header_keep_reg;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed self-checking bench for axi_stream_strip_header.
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic [2:0]  strip_cnt = '0;
    logic        header_valid;
    logic [31:0] header_data;
    logic [3:0]  header_keep;
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
    logic        err_short_pkt;
`endif

    logic ready_main = 1'b1;
    logic tog_mode   = 1'b0;
    logic tog_ready  = 1'b1;
    int   tog_cnt    = 0;
    int   err_cnt    = 0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t       out_q[$];
    logic [35:0] hdr_q[$];
    logic        stalled_prev = 1'b0;
    beat_t       prev_beat;

    assign ready_out = tog_mode ? tog_ready : ready_main;

    axi_stream_strip_header dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .strip_cnt    (strip_cnt),
        .header_valid (header_valid),
        .header_data  (header_data),
        .header_keep  (header_keep)
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
        ,
        .err_short_pkt(err_short_pkt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready pattern: three cycles high, three cycles low.
    always @(posedge clk) begin
        #1;
        if (tog_mode) begin
            tog_cnt = tog_cnt + 1;
            if (tog_cnt == 3) begin
                tog_cnt   = 0;
                tog_ready = ~tog_ready;
            end
        end else begin
            tog_cnt   = 0;
            tog_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled_prev) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_beat", 64'({data_out, keep_out, last_out}), 64'(prev_beat));
            end
            if (valid_out && ready_out) begin
                out_q.push_back({data_out, keep_out, last_out});
                $display("out  data=%h keep=%b last=%0d", data_out, keep_out, last_out);
            end
            if (header_valid) begin
                hdr_q.push_back({header_data, header_keep});
                $display("hdr  data=%h keep=%b", header_data, header_keep);
            end
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
            if (err_short_pkt) err_cnt++;
`endif
            stalled_prev = valid_out && !ready_out;
            prev_beat    = {data_out, keep_out, last_out};
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        n = 0;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) check("ready_in_timeout", 64'(ready_in), 64'd1);
        $display("in   data=%h keep=%b last=%0d", d, k, l);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input string tag, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
        if (out_q.size() > idx) check(tag, 64'(out_q[idx]), 64'({d, k, l}));
        else check({tag, "_missing"}, 64'(out_q.size()), 64'(idx + 1));
    endtask

    task automatic exp_hdr(input string tag, input logic [31:0] d, input logic [3:0] k);
        check({tag, "_hdr_cnt"}, 64'(hdr_q.size()), 64'd1);
        if (hdr_q.size() > 0) check({tag, "_hdr"}, 64'(hdr_q[0]), 64'({d, k}));
    endtask

    task automatic clear_q();
        out_q.delete();
        hdr_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state.
        #2;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_out", 64'({data_out, keep_out, last_out}), 64'd0);
        check("rst_hdr", 64'({header_valid, header_data, header_keep}), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Strip 2 from three full beats.
        clear_q();
        strip_cnt = 3'd2;
        send_beat(32'h00010203, 4'hF, 1'b0);
        send_beat(32'h04050607, 4'hF, 1'b0);
        send_beat(32'h08090A0B, 4'hF, 1'b1);
        idle(8);
        exp_hdr("t1", 32'h00010000, 4'b1100);
        check("t1_cnt", 64'(out_q.size()), 64'd3);
        exp_beat("t1_b0", 0, 32'h02030405, 4'hF, 1'b0);
        exp_beat("t1_b1", 1, 32'h06070809, 4'hF, 1'b0);
        exp_beat("t1_b2", 2, 32'h0A0B0000, 4'b1100, 1'b1);

        // Strip 1 with a flush beat, stalled downstream while it is held.
        clear_q();
        strip_cnt = 3'd1;
        send_beat(32'hA0A1A2A3, 4'hF, 1'b0);
        send_beat(32'hB0B1B2B3, 4'hE, 1'b1);
        check("t2_ready_in_flush", 64'(ready_in), 64'd0);
        idle(1);
        ready_main = 1'b0;
        idle(5);
        check("t2_flush_held", 64'({valid_out, data_out, keep_out, last_out}),
              64'({1'b1, 32'hB1B20000, 4'b1100, 1'b1}));
        ready_main = 1'b1;
        idle(5);
        exp_hdr("t2", 32'hA0000000, 4'b1000);
        check("t2_cnt", 64'(out_q.size()), 64'd2);
        exp_beat("t2_b0", 0, 32'hA1A2A3B0, 4'hF, 1'b0);
        exp_beat("t2_b1", 1, 32'hB1B20000, 4'b1100, 1'b1);

        // Strip 0 pass-through with toggling backpressure.
        clear_q();
        strip_cnt = 3'd0;
        tog_mode  = 1'b1;
        for (int i = 0; i < 20; i++)
            send_beat({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 4'hF, i == 19);
        idle(12);
        tog_mode = 1'b0;
        idle(2);
        exp_hdr("t3", 32'h0, 4'h0);
        check("t3_cnt", 64'(out_q.size()), 64'd20);
        for (int i = 0; i < 20; i++)
            exp_beat("t3_beat", i, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 4'hF, i == 19);

        // Whole single-beat packet consumed as header.
        clear_q();
        strip_cnt = 3'd4;
        send_beat(32'hDEADBEEF, 4'hF, 1'b1);
        idle(5);
        exp_hdr("t4", 32'hDEADBEEF, 4'hF);
        check("t4_no_out", 64'(out_q.size()), 64'd0);
`ifdef AXIS_STRIP_SHORT_PKT_ERR_EN
        check("t4_err_pulse", 64'(err_cnt), 64'd1);
`endif

        // Strip 3, last beat keep 1110, output held under stall then sent once.
        clear_q();
        strip_cnt = 3'd3;
        send_beat(32'h10111213, 4'hF, 1'b0);
        send_beat(32'h20212223, 4'hE, 1'b1);
        ready_main = 1'b0;
        idle(5);
        check("t5_held", 64'({valid_out, data_out, keep_out, last_out}),
              64'({1'b1, 32'h13202122, 4'hF, 1'b1}));
        ready_main = 1'b1;
        idle(4);
        exp_hdr("t5", 32'h10111200, 4'b1110);
        check("t5_cnt", 64'(out_q.size()), 64'd1);
        exp_beat("t5_b0", 0, 32'h13202122, 4'hF, 1'b1);

        // Reset mid-packet with two residual bytes pending.
        clear_q();
        strip_cnt = 3'd2;
        send_beat(32'h11121314, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_out", 64'({valid_out, data_out, keep_out, last_out}), 64'd0);
        check("t6_rst_hdr", 64'({header_valid, header_data, header_keep}), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        clear_q();
        send_beat(32'h21222324, 4'hF, 1'b0);
        send_beat(32'h25262728, 4'hF, 1'b1);
        idle(8);
        exp_hdr("t6", 32'h21220000, 4'b1100);
        check("t6_cnt", 64'(out_q.size()), 64'd2);
        exp_beat("t6_b0", 0, 32'h23242526, 4'hF, 1'b0);
        exp_beat("t6_b1", 1, 32'h27280000, 4'b1100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
